// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension execute unit:
// funct3 op codes, FSM states and op-class decode helpers.
package muldiv_pkg;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] f);
    return f[2] && f[1];
  endfunction

  function automatic logic is_high(input logic [2:0] f);
    return !f[2] && (f != F_MUL);
  endfunction

  function automatic logic rs1_signed(input logic [2:0] f);
    return !((f == F_MULHU) || (f == F_DIVU) || (f == F_REMU));
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f);
    return (f == F_MUL) || (f == F_MULH) ||
           (f == F_DIV) || (f == F_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_div.sv
// Restoring radix-2 divider step on magnitudes plus
// its iteration counter; one quotient bit per enabled cycle.
import muldiv_pkg::*;

module ex_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            en,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem,
  output logic            last
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] d_q;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  assign shifted = {rem, quot[XLEN-1]};
  assign diff    = shifted - {1'b0, d_q};
  assign last    = (cnt == CW'(XLEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quot <= '0;
      rem  <= '0;
      d_q  <= '0;
      cnt  <= '0;
    end else if (start) begin
      quot <= dividend;
      rem  <= '0;
      d_q  <= divisor;
      cnt  <= '0;
    end else if (en) begin
      // diff[XLEN] set means the trial subtract borrowed: restore
      quot <= {quot[XLEN-2:0], ~diff[XLEN]};
      rem  <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV M-extension execute unit: iterative multiply/divide
// beside the EX ALU, with hold/flush and event counters.
import muldiv_pkg::*;

module ex_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_ITER = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             keep,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [4:0]       wreg_in,
  output logic             busy,
  output logic             res_valid,
  output logic [XLEN-1:0]  result,
  output logic [4:0]       res_wreg,
  output logic [CNT_W-1:0] mul_count,
  output logic [CNT_W-1:0] div_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [2:0]        op_q;
  logic [4:0]        wreg_q;
  logic              sg1_q;
  logic              sg2_q;
  logic [XLEN-1:0]   a_q;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     mcnt;

  logic              accept;
  logic              sg1;
  logic              sg2;
  logic [XLEN-1:0]   abs1;
  logic [XLEN-1:0]   abs2;
  logic              div0;
  logic              ovf;
  logic              special;
  logic [XLEN-1:0]   spec_res;
  logic [2*XLEN-1:0] now_prod;
  logic [XLEN-1:0]   now_res;
  logic [XLEN:0]     msum;
  logic [2*XLEN-1:0] mfull;
  logic [XLEN-1:0]   qs;
  logic [XLEN-1:0]   rs;
  logic [XLEN-1:0]   fix_res;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic              div_last;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready && !flush;
  assign busy      = accept ||
                     (state inside {S_MUL, S_DIV, S_FIX});

  always_comb begin
    sg1  = rs1_signed(funct3) && rs1[XLEN-1];
    sg2  = rs2_signed(funct3) && rs2[XLEN-1];
    abs1 = sg1 ? -rs1 : rs1;
    abs2 = sg2 ? -rs2 : rs2;
    div0 = is_div(funct3) && (rs2 == '0);
    ovf  = is_div(funct3) && !funct3[0] &&
           (rs1 == MIN_NEG) && (rs2 == '1);
    special = div0 || ovf;
    if (div0)
      spec_res = is_rem(funct3) ? rs1 : '1;
    else
      spec_res = is_rem(funct3) ? '0 : rs1;
    now_prod = {{XLEN{1'b0}}, abs1} *
               {{XLEN{1'b0}}, abs2};
    if (sg1 ^ sg2)
      now_prod = -now_prod;
    now_res = is_high(funct3) ? now_prod[2*XLEN-1:XLEN]
                              : now_prod[XLEN-1:0];
  end

  always_comb begin
    msum  = {1'b0, acc[2*XLEN-1:XLEN]} +
            (acc[0] ? {1'b0, a_q} : '0);
    mfull = (sg1_q ^ sg2_q) ? -acc : acc;
    qs    = (sg1_q ^ sg2_q) ? -quot : quot;
    rs    = sg1_q ? -rem : rem;
    unique case (1'b1)
      is_rem(op_q):
        fix_res = rs;
      is_div(op_q) && !is_rem(op_q):
        fix_res = qs;
      is_high(op_q):
        fix_res = mfull[2*XLEN-1:XLEN];
      default:
        fix_res = mfull[XLEN-1:0];
    endcase
  end

  ex_div_iter #(
    .XLEN(XLEN)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_div(funct3) && !special),
    .en      (state == S_DIV),
    .dividend(abs1),
    .divisor (abs2),
    .quot    (quot),
    .rem     (rem),
    .last    (div_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      op_q        <= '0;
      wreg_q      <= '0;
      sg1_q       <= 1'b0;
      sg2_q       <= 1'b0;
      a_q         <= '0;
      acc         <= '0;
      mcnt        <= '0;
      res_valid   <= 1'b0;
      result      <= '0;
      res_wreg    <= '0;
      mul_count   <= '0;
      div_count   <= '0;
      stall_count <= '0;
    end else begin
      if (busy)
        stall_count <= stall_count + CNT_W'(1);
      if (flush) begin
        state     <= S_IDLE;
        res_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              op_q   <= funct3;
              wreg_q <= wreg_in;
              sg1_q  <= sg1;
              sg2_q  <= sg2;
              a_q    <= abs1;
              acc    <= {{XLEN{1'b0}}, abs2};
              mcnt   <= '0;
              if (special) begin
                result    <= spec_res;
                res_wreg  <= wreg_in;
                res_valid <= 1'b1;
                div_count <= div_count + CNT_W'(1);
                state     <= S_DONE;
              end else if (is_div(funct3)) begin
                state <= S_DIV;
              end else if (MUL_ITER == 0) begin
                result    <= now_res;
                res_wreg  <= wreg_in;
                res_valid <= 1'b1;
                mul_count <= mul_count + CNT_W'(1);
                state     <= S_DONE;
              end else begin
                state <= S_MUL;
              end
            end
          end
          S_MUL: begin
            acc  <= {msum, acc[XLEN-1:1]};
            mcnt <= mcnt + CW'(1);
            if (mcnt == CW'(XLEN - 1))
              state <= S_FIX;
          end
          S_DIV: begin
            if (div_last)
              state <= S_FIX;
          end
          S_FIX: begin
            result    <= fix_res;
            res_wreg  <= wreg_q;
            res_valid <= 1'b1;
            if (is_div(op_q))
              div_count <= div_count + CNT_W'(1);
            else
              mul_count <= mul_count + CNT_W'(1);
            state <= S_DONE;
          end
          S_DONE: begin
            if (!keep) begin
              state     <= S_IDLE;
              res_valid <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed literal cases plus
// randomized ops against a transaction-level reference model.
module tb_ex_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;
  localparam int LAT   = XLEN + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        keep = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [4:0]  wreg_in = '0;
  logic        req_ready;
  logic        busy;
  logic        res_valid;
  logic [31:0] result;
  logic [4:0]  res_wreg;
  logic [31:0] mul_count;
  logic [31:0] div_count;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(
    .XLEN(XLEN), .MUL_ITER(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .keep(keep),
    .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .wreg_in(wreg_in), .busy(busy),
    .res_valid(res_valid), .result(result),
    .res_wreg(res_wreg), .mul_count(mul_count),
    .div_count(div_count), .stall_count(stall_count)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the ISA definition
  function automatic logic [31:0] ref_calc(
      input logic [2:0] f,
      input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] f,
      input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) ||
      (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Model: cycles left until the result appears, or presenting it
  int          m_left;
  bit          m_done;
  logic [31:0] m_res, m_pres;
  logic [4:0]  m_wreg, m_pwreg;
  bit          m_pdiv;
  logic [31:0] m_mul, m_div, m_stall;
  logic        m_idle, m_acc, m_busy;

  assign m_idle = !m_done && (m_left == 0);
  assign m_acc  = req_valid && m_idle && !flush;
  assign m_busy = m_acc || (m_left > 0);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left <= 0; m_done <= 0; m_res <= 0; m_wreg <= 0;
      m_pres <= 0; m_pwreg <= 0; m_pdiv <= 0;
      m_mul <= 0; m_div <= 0; m_stall <= 0;
    end else begin
      if (m_busy) m_stall <= m_stall + 1;
      if (flush) begin
        m_left <= 0;
        m_done <= 0;
      end else if (m_done) begin
        if (!keep) m_done <= 0;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1;
          m_res  <= m_pres;
          m_wreg <= m_pwreg;
          if (m_pdiv) m_div <= m_div + 1;
          else m_mul <= m_mul + 1;
        end
      end else if (m_acc) begin
        if (is_special(funct3, rs1, rs2)) begin
          m_done <= 1;
          m_res  <= ref_calc(funct3, rs1, rs2);
          m_wreg <= wreg_in;
          m_div  <= m_div + 1;
        end else begin
          m_left <= LAT - 1;
          m_pres <= ref_calc(funct3, rs1, rs2);
          m_pwreg <= wreg_in;
          m_pdiv <= funct3[2];
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("req_ready", req_ready, m_idle);
    chk("busy", busy, m_busy);
    chk("res_valid", res_valid, m_done);
    if (m_done) begin
      chk("result", result, m_res);
      chk("res_wreg", res_wreg, m_wreg);
    end
    chk("mul_count", mul_count, m_mul);
    chk("div_count", div_count, m_div);
    chk("stall_count", stall_count, m_stall);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] w);
    int n = 0;
    while (!req_ready && n < 200) begin tick(); n++; end
    if (n >= 200) chk("ready_timeout", req_ready, 1);
    funct3 = f; rs1 = a; rs2 = b; wreg_in = w;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 1;
    while (!res_valid && lat < 100) begin tick(); lat++; end
    if (!res_valid) chk("res_timeout", res_valid, 1);
  endtask

  task automatic directed(input string nm, input logic [2:0] f,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] exp, input int exp_lat);
    int lat;
    chk({nm, "_model"}, ref_calc(f, a, b), exp);
    issue(f, a, b, 5'(f + 3));
    wait_res(lat);
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_res"}, result, exp);
    tick();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int lat;
    logic [31:0] held, dsave;
    repeat (3) tick();
    chk("rst_result", result, 0);
    chk("rst_wreg", res_wreg, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", res_valid, 0);
    rst = 1'b1;
    tick();

    directed("mul", 3'd0, 7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT);
    chk("mul_cnt1", mul_count, 1);
    directed("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000,
             32'h4000_0000, LAT);
    directed("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFE, LAT);
    directed("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFF, LAT);
    directed("div", 3'd4, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, LAT);
    directed("rem", 3'd6, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, LAT);
    directed("divu", 3'd5, 100, 7, 14, LAT);
    directed("remu", 3'd7, 100, 7, 2, LAT);
    directed("div0", 3'd4, 5, 0, 32'hFFFF_FFFF, 1);
    directed("rem0", 3'd6, 5, 0, 5, 1);
    directed("divu0", 3'd5, 9, 0, 32'hFFFF_FFFF, 1);
    directed("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h8000_0000, 1);
    directed("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);

    dsave = div_count;
    issue(3'd4, 1000, 3, 5'd9);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", res_valid, 0);
    chk("flush_ready", req_ready, 1);
    repeat (40) tick();
    chk("flush_divcnt", div_count, dsave);
    directed("mulhu2", 3'd3, 32'h0001_0000, 32'h0001_0000, 1, LAT);

    issue(3'd5, 50, 5, 5'd17);
    keep = 1'b1;
    wait_res(lat);
    held = result;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("keep_res", result, held);
      chk("keep_wreg", res_wreg, 17);
      chk("keep_valid", res_valid, 1);
    end
    keep = 1'b0;
    tick();
    chk("keep_drop", res_valid, 0);
    chk("keep_idle", req_ready, 1);

    funct3 = 3'd0; rs1 = 3; rs2 = 4;
    flush = 1'b1; req_valid = 1'b1;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    chk("flushreq_ready", req_ready, 1);
    chk("flushreq_busy", busy, 0);

    issue(3'd0, 12, 13, 5'd4);
    repeat (5) tick();
    rst = 1'b0;
    #1;
    chk("arst_valid", res_valid, 0);
    chk("arst_stall", stall_count, 0);
    chk("arst_result", result, 0);
    tick();
    rst = 1'b1;
    tick();

    for (int k = 0; k < 80; k++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      issue(f, a, b, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 40)) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end else begin
        keep = 1'($urandom_range(0, 1));
        wait_res(lat);
        chk("rnd_res", result, ref_calc(f, a, b));
        if (keep) repeat ($urandom_range(1, 3)) tick();
        keep = 1'b0;
        tick();
      end
    end
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
